spi_master_periph: RTL and testbench

APB slave peripheral giving the RV32I core a single-byte, full-duplex SPI master. It is attached to one free PSEL/PRDATA/PREADY slot of APB_Master, alongside the GPIO, FND, timer and UART peripherals. Software writes a byte to TDR, and the block runs the transfer and raises a completion flag. Mode (CPOL/CPHA) and clock divider are programmable.

---
 rtl/spi_master_periph_if.sv | 20 ++
 rtl/spi_master_periph.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_periph.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_periph_if.sv
// APB bus bundle between the APB master and the SPI master peripheral.
interface spi_master_periph_if;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/spi_master_periph.sv
// Single-byte full-duplex SPI master behind an APB slave port.
// Registers: CR (EN/CPOL/CPHA/CLKDIV), SR (BUSY/DONE/OVR), TDR, RDR.
module spi_master_periph #(
  parameter int unsigned CLKDIV_W = 8
) (
  input  logic               PCLK,
  input  logic               PRESET,
  spi_master_periph_if.slave apb,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO,
  output logic               CS_n
);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

  state_e              state_q;
  logic                en_q, cpol_q, cpha_q;
  logic [CLKDIV_W-1:0] clkdiv_q;
  logic                done_q, ovr_q;
  logic [7:0]          rdr_q, shreg_q;
  logic                cpol_l_q, cpha_l_q;
  logic [CLKDIV_W-1:0] div_l_q, cnt_q;
  logic [3:0]          edge_q;
  logic                sclk_q, mosi_q, cs_n_q;
  logic                pready_q;
  logic [31:0]         prdata_q;

  logic        access, wr_cr, wr_sr, wr_tdr, busy, tick;
  logic [1:0]  sel;
  logic [31:0] rdata;
  logic        unused_bits;

  assign sel    = apb.PADDR[3:2];
  // Side effects happen only in the PREADY=1 cycle of an access.
  assign access = apb.PSEL & apb.PENABLE & pready_q;
  assign wr_cr  = access & apb.PWRITE & (sel == 2'd0);
  assign wr_sr  = access & apb.PWRITE & (sel == 2'd1);
  assign wr_tdr = access & apb.PWRITE & (sel == 2'd2);
  assign busy   = (state_q != StIdle);
  assign tick   = (cnt_q == div_l_q);

  assign unused_bits = ^{apb.PWDATA[31:8+CLKDIV_W], apb.PADDR[1:0]};

  assign apb.PREADY = pready_q;
  assign apb.PRDATA = prdata_q;
  assign SCLK       = sclk_q;
  assign MOSI       = mosi_q;
  assign CS_n       = cs_n_q;

  // Register read mux; reserved bits and TDR read as zero.
  always_comb begin
    rdata = '0;
    case (sel)
      2'd0: begin
        rdata[0]              = en_q;
        rdata[1]              = cpol_q;
        rdata[2]              = cpha_q;
        rdata[8 +: CLKDIV_W]  = clkdiv_q;
      end
      2'd1:    rdata[2:0] = {ovr_q, done_q, busy};
      2'd3:    rdata[7:0] = rdr_q;
      default: rdata      = '0;
    endcase
  end

  // APB handshake: one wait state, PRDATA only driven alongside PREADY.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else if (apb.PSEL && apb.PENABLE && !pready_q) begin
      pready_q <= 1'b1;
      prdata_q <= rdata;
    end else begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end
  end

  // Register file, transfer FSM and SPI pin drivers.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      clkdiv_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      rdr_q    <= '0;
      shreg_q  <= '0;
      cpol_l_q <= 1'b0;
      cpha_l_q <= 1'b0;
      div_l_q  <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      if (wr_cr) begin
        en_q     <= apb.PWDATA[0];
        cpol_q   <= apb.PWDATA[1];
        cpha_q   <= apb.PWDATA[2];
        clkdiv_q <= apb.PWDATA[8 +: CLKDIV_W];
      end
      // Clears come first so a hardware DONE set later in this block wins.
      if (wr_sr) begin
        if (apb.PWDATA[1]) done_q <= 1'b0;
        if (apb.PWDATA[2]) ovr_q  <= 1'b0;
      end
      if (wr_tdr && en_q && busy) ovr_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          cs_n_q <= 1'b1;
          sclk_q <= cpol_q;
          if (wr_tdr && en_q) begin
            state_q  <= StSetup;
            cs_n_q   <= 1'b0;
            done_q   <= 1'b0;
            shreg_q  <= apb.PWDATA[7:0];
            cpol_l_q <= cpol_q;
            cpha_l_q <= cpha_q;
            div_l_q  <= clkdiv_q;
            cnt_q    <= '0;
            edge_q   <= '0;
            if (!cpha_q) mosi_q <= apb.PWDATA[7];
          end
        end
        StSetup: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= StXfer;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StXfer: begin
          if (tick) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 4'd1;
            // Even edge count = leading edge of a bit.
            if (!edge_q[0]) begin
              if (!cpha_l_q) shreg_q <= {shreg_q[6:0], MISO};
              else           mosi_q  <= shreg_q[7];
            end else begin
              if (!cpha_l_q) mosi_q  <= shreg_q[7];
              else           shreg_q <= {shreg_q[6:0], MISO};
            end
            if (edge_q == 4'd15) state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            rdr_q   <= shreg_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Clearing EN mid-transfer aborts without completing.
      if (wr_cr && !apb.PWDATA[0] && busy) begin
        state_q <= StIdle;
        cs_n_q  <= 1'b1;
        sclk_q  <= apb.PWDATA[1];
        cnt_q   <= '0;
        edge_q  <= '0;
        done_q  <= done_q;
        rdr_q   <= rdr_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_periph.sv
// Testbench for spi_master_periph: register table, directed SPI transfers and
// randomized transfers against a behavioural SPI slave.
module tb_spi_master_periph;

  logic PCLK = 1'b0;
  logic PRESET = 1'b0;
  wire  SCLK, MOSI, MISO, CS_n;

  spi_master_periph_if apb ();

  spi_master_periph #(.CLKDIV_W(8)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (apb),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .CS_n   (CS_n)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural SPI slave: loads s_load on CS_n fall, samples MOSI and drives
  // MISO according to the configured mode.
  logic [7:0] s_load = 8'h00;
  logic       s_cpol = 1'b0, s_cpha = 1'b0;
  bit         lb = 1'b0;
  logic [7:0] s_out = 8'h00, s_in = 8'h00;
  logic       miso_drv = 1'b0, s_act = 1'b0, s_sclk = 1'b0;

  assign MISO = lb ? MOSI : miso_drv;

  always @(SCLK or CS_n) begin
    if (CS_n) begin
      s_act = 1'b0;
    end else if (!s_act) begin
      s_act = 1'b1;
      s_out = s_load;
      s_in  = 8'h00;
      if (!s_cpha) miso_drv = s_out[7];
    end else if (SCLK !== s_sclk) begin
      if ((SCLK != s_cpol) == !s_cpha) begin
        s_in = {s_in[6:0], MOSI};
      end else if (!s_cpha) begin
        s_out    = s_out << 1;
        miso_drv = s_out[7];
      end else begin
        miso_drv = s_out[7];
        s_out    = s_out << 1;
      end
    end
    s_sclk = SCLK;
  end

  // Pin monitor: cumulative counts of CS_n-low cycles, SCLK edges and bad gaps.
  int   cyc = 0, cs_low = 0, edges = 0, gap_err = 0, last_rise = -1;
  int   exp_gap = 4;
  logic sclk_prev = 1'b0;

  always @(negedge PCLK) begin
    cyc++;
    if (CS_n) begin
      last_rise = -1;
    end else begin
      cs_low++;
      if (SCLK !== sclk_prev) begin
        edges++;
        if (SCLK) begin
          if (last_rise >= 0 && (cyc - last_rise) != exp_gap) gap_err++;
          last_rise = cyc;
        end
      end
    end
    sclk_prev = SCLK;
  end

  logic cs_after, sclk_after;

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
    apb.PADDR = addr; apb.PWDATA = wdata;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    check("wait_state", {31'b0, apb.PREADY}, 32'd0);
    check("prdata_idle", apb.PRDATA, 32'd0);
    @(negedge PCLK);
    check("pready_high", {31'b0, apb.PREADY}, 32'd1);
    rdata = apb.PRDATA;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    @(negedge PCLK);
    check("pready_drop", {31'b0, apb.PREADY}, 32'd0);
    cs_after   = CS_n;
    sclk_after = SCLK;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] d;
    apb_xfer(1'b1, addr, data, d);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_xfer(1'b0, addr, 32'h0, d);
    check(name, d, exp);
  endtask

  int         cs0, e0, g0;
  logic [7:0] exp_rdr = 8'h00;

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sbyte, input logic cpol,
                            input logic cpha, input int div, input bit loop);
    logic [31:0] cr;
    s_load = sbyte; s_cpol = cpol; s_cpha = cpha; lb = loop;
    exp_gap = 2 * (div + 1);
    cr = 32'h0; cr[0] = 1'b1; cr[1] = cpol; cr[2] = cpha; cr[15:8] = div[7:0];
    wr(4'h0, cr);
    cs0 = cs_low; e0 = edges; g0 = gap_err;
    wr(4'h8, {24'hABCDEF, tx});
  endtask

  task automatic finish_xfer(input logic [7:0] tx, input logic [7:0] rx, input int div,
                             input logic [31:0] exp_sr, input logic idle);
    int k = 0;
    while (CS_n === 1'b0 && k < 18 * (div + 1) + 40) begin
      @(negedge PCLK);
      k++;
    end
    check("xfer_timeout", {31'b0, CS_n}, 32'd1);
    check("cs_low_cycles", cs_low - cs0, 18 * (div + 1));
    check("sclk_edges", edges - e0, 16);
    check("sclk_gap", gap_err - g0, 0);
    check("slave_rx", {24'b0, s_in}, {24'b0, tx});
    rd_chk("rdr", 4'hC, {24'b0, rx});
    exp_rdr = rx;
    rd_chk("sr_after", 4'h4, exp_sr);
    check("sclk_idle", {31'b0, SCLK}, {31'b0, idle});
  endtask

  task automatic wait_edges(input int n);
    int k = 0;
    while ((edges - e0) < n && k < 300) begin
      @(negedge PCLK);
      k++;
    end
    check("edge_wait", {31'b0, ((edges - e0) >= n)}, 32'd1);
  endtask

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        sclk;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  tx, sb;
    logic        cp, ch, ncp, nch, idle;
    int          div, ndiv;
    bit          loop;
    logic [31:0] cr;

    vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{1'b0, 4'hC, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b0, 4'h8, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b1, 4'h0, 32'hFFFF_FF06, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 4'h0, 32'h0,         32'h0000_FF06, 1'b1};
    vecs[6]  = '{1'b1, 4'h8, 32'h0000_0055, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 4'h4, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 4'hC, 32'h0000_00FF, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 4'hC, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b1, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[13] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0};

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 4'h0; apb.PWDATA = 32'h0;

    // Reset held for three edges.
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_cs_n", {31'b0, CS_n}, 32'd1);
    check("rst_sclk", {31'b0, SCLK}, 32'd0);
    check("rst_mosi", {31'b0, MOSI}, 32'd0);
    check("rst_pready", {31'b0, apb.PREADY}, 32'd0);
    check("rst_prdata", apb.PRDATA, 32'd0);
    PRESET = 1'b1;

    // Register map table.
    for (int i = 0; i < 14; i++) begin
      logic [31:0] d;
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, d);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      @(negedge PCLK);
      check($sformatf("vec%0d_cs_n", i), {31'b0, CS_n}, 32'd1);
      check($sformatf("vec%0d_sclk", i), {31'b0, SCLK}, {31'b0, vecs[i].sclk});
    end

    // Mode 0 loopback, h=2.
    start_xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1, 1'b1);
    finish_xfer(8'hA5, 8'hA5, 1, 32'h2, 1'b0);

    // Mode 3 with slave returning 0x3C.
    start_xfer(8'h81, 8'h3C, 1'b1, 1'b1, 0, 1'b0);
    finish_xfer(8'h81, 8'h3C, 0, 32'h2, 1'b1);

    // Overrun and write-1-to-clear.
    start_xfer(8'h11, 8'h00, 1'b0, 1'b0, 1, 1'b1);
    wr(4'h8, 32'h22);
    rd_chk("sr_overrun", 4'h4, 32'h5);
    finish_xfer(8'h11, 8'h11, 1, 32'h6, 1'b0);
    wr(4'h4, 32'h6);
    rd_chk("sr_cleared", 4'h4, 32'h0);

    // Abort by clearing EN after 5 edges.
    start_xfer(8'h5A, 8'hC3, 1'b0, 1'b0, 3, 1'b0);
    wait_edges(5);
    wr(4'h0, 32'h0);
    check("abort_cs_n", {31'b0, cs_after}, 32'd1);
    check("abort_sclk", {31'b0, sclk_after}, 32'd0);
    rd_chk("abort_sr", 4'h4, 32'h0);
    rd_chk("abort_rdr", 4'hC, {24'b0, exp_rdr});

    // Reset in the middle of a transfer.
    start_xfer(8'hC3, 8'h5A, 1'b0, 1'b0, 1, 1'b0);
    wait_edges(3);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("midrst_cs_n", {31'b0, CS_n}, 32'd1);
    check("midrst_sclk", {31'b0, SCLK}, 32'd0);
    check("midrst_mosi", {31'b0, MOSI}, 32'd0);
    PRESET = 1'b1;
    rd_chk("midrst_cr", 4'h0, 32'h0);
    rd_chk("midrst_sr", 4'h4, 32'h0);
    rd_chk("midrst_rdr", 4'hC, 32'h0);
    start_xfer(8'h3E, 8'hE7, 1'b0, 1'b1, 2, 1'b0);
    finish_xfer(8'h3E, 8'hE7, 2, 32'h2, 1'b0);

    // Randomized transfers, sometimes rewriting CR mid-transfer.
    for (int i = 0; i < 10; i++) begin
      tx   = 8'($urandom_range(255));
      sb   = 8'($urandom_range(255));
      cp   = 1'($urandom_range(1));
      ch   = 1'($urandom_range(1));
      div  = (i == 0) ? 0 : int'($urandom_range(3));
      loop = bit'($urandom_range(1));
      idle = cp;
      start_xfer(tx, sb, cp, ch, div, loop);
      if ($urandom_range(1) == 1) begin
        ncp  = 1'($urandom_range(1));
        nch  = 1'($urandom_range(1));
        ndiv = int'($urandom_range(7));
        cr = 32'h0; cr[0] = 1'b1; cr[1] = ncp; cr[2] = nch; cr[15:8] = ndiv[7:0];
        wr(4'h0, cr);
        idle = ncp;
      end
      finish_xfer(tx, loop ? tx : sb, div, 32'h2, idle);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
